// File: rtl/filterbank_sequencer.sv
// rtl/filterbank_sequencer.sv - sample/phase sequencer for the 16-channel serial filterbank MAC
// Optional overrun counter port enabled by defining FBSEQ_OVERRUN_CNT_EN.
module filterbank_sequencer #(
    parameter int DATA_W     = 13,
    parameter int NUM_PHASES = 60,
    parameter int PHASE_W    = 6
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clk_enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic [DATA_W-1:0]  sample_out,
    output logic               shift_en,
    output logic [PHASE_W-1:0] phase,
    output logic               acc_clr,
    output logic               acc_en,
    output logic               phase_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
`ifdef FBSEQ_OVERRUN_CNT_EN
    ,
    output logic [15:0]        overrun_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DUMP = 2'd2
    } state_t;

    localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

    state_t state;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            phase      <= '0;
            sample_out <= '0;
        end else if (clk_enable) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sample_out <= in_data;
                        phase      <= '0;
                        state      <= MAC;
                    end
                end
                MAC: begin
                    if (phase == LAST_PHASE) begin
                        phase <= '0;
                        state <= DUMP;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                DUMP: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Enables are gated by clk_enable so a frozen cycle never shifts or accumulates.
    assign in_ready   = (state == IDLE) & clk_enable & reset;
    assign acc_en     = (state == MAC) & clk_enable;
    assign shift_en   = acc_en & (phase == '0);
    assign acc_clr    = shift_en;
    assign phase_last = (state == MAC) & (phase == LAST_PHASE);
    assign out_valid  = (state == DUMP);
    assign busy       = (state != IDLE);

`ifdef FBSEQ_OVERRUN_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            overrun_cnt <= '0;
        end else if (in_valid & ~in_ready & clk_enable & (overrun_cnt != 16'hFFFF)) begin
            overrun_cnt <= overrun_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_filterbank_sequencer.sv
// tb/tb_filterbank_sequencer.sv - directed self-checking bench for filterbank_sequencer
module tb_filterbank_sequencer;

    logic        clock = 1'b0;
    logic        reset, clk_enable, in_valid, out_ready;
    logic        in_ready, shift_en, acc_clr, acc_en, phase_last, out_valid, busy;
    logic [12:0] in_data, sample_out;
    logic [5:0]  phase;
`ifdef FBSEQ_OVERRUN_CNT_EN
    logic [15:0] overrun_cnt;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    filterbank_sequencer dut (
        .clock(clock), .reset(reset), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .sample_out(sample_out), .shift_en(shift_en), .phase(phase),
        .acc_clr(acc_clr), .acc_en(acc_en), .phase_last(phase_last),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
`ifdef FBSEQ_OVERRUN_CNT_EN
        , .overrun_cnt(overrun_cnt)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
        cyc++;
    endtask

    // Offer one sample in IDLE; returns the cycle index of the handshake cycle T.
    task automatic send(input logic [12:0] d, output int t0);
        in_data  = d;
        in_valid = 1'b1;
        t0 = cyc;
        tick();
        in_valid = 1'b0;
    endtask

    int t0, n_acc, n_sh, n_ov, n_ir, held, frozen, t_last;
`ifdef FBSEQ_OVERRUN_CNT_EN
    logic [15:0] c0;
`endif

    initial begin
        reset = 1'b0; clk_enable = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;

        // 1: reset held three cycles
        repeat (3) tick();
        check("ready_in_reset", in_ready, 0);
        reset = 1'b1;
        tick();
        check("rst_phase", phase, 0);
        check("rst_sample", sample_out, 0);
        check("rst_ctrl", {shift_en, acc_clr, acc_en, phase_last, out_valid, busy}, 0);
        check("rst_ready", in_ready, 1);

        // 2: single sample, full timeline
        send(13'h0ABC, t0);
        check("s2_shift", shift_en, 1);
        check("s2_clr", acc_clr, 1);
        check("s2_sample", sample_out, 13'h0ABC);
        check("s2_phase0", phase, 0);
        n_acc = 1; n_sh = 1; t_last = -1;
        for (int k = 2; k <= 60; k++) begin
            tick();
            n_acc += acc_en;
            n_sh  += shift_en;
            if (phase_last && t_last < 0) t_last = cyc - t0;
        end
        check("s2_acc_cycles", n_acc, 60);
        check("s2_shift_pulses", n_sh, 1);
        check("s2_last_at", t_last, 60);
        check("s2_phase59", phase, 59);
        tick();
        check("s2_ov_T61", out_valid, 1);
        check("s2_acc_off", acc_en, 0);
        check("s2_phase_wrap", phase, 0);
        tick();
        check("s2_ov_drop", out_valid, 0);
        check("s2_ready_T62", in_ready, 1);

        // 3: in_valid held high for ten sample periods
        in_valid = 1'b1; n_acc = 0; n_sh = 0; n_ov = 0;
        for (int i = 0; i < 620; i++) begin
            in_data = 13'(i);
            if (in_valid && in_ready) n_acc++;
            tick();
            n_sh += shift_en;
            n_ov += out_valid;
        end
        in_valid = 1'b0;
        check("s3_accepted", n_acc, 10);
        check("s3_shift_pulses", n_sh, 10);
        check("s3_ov_pulses", n_ov, 10);
        tick();
        check("s3_idle", busy, 0);

        // 4: downstream stalls 20 cycles
        out_ready = 1'b0;
        in_data = 13'h1234;
        in_valid = 1'b1;
        tick();
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        check("s4_reached_dump", out_valid, 1);
`ifdef FBSEQ_OVERRUN_CNT_EN
        c0 = overrun_cnt;
`endif
        held = 0; n_ir = 0;
        for (int k = 0; k < 20; k++) begin
            held += out_valid;
            n_ir += in_ready;
            if (k != 19) tick();
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        tick();
        check("s4_ov_held", held, 20);
        check("s4_ready_low", n_ir, 0);
        check("s4_released", out_valid, 0);
`ifdef FBSEQ_OVERRUN_CNT_EN
        check("s4_overrun", overrun_cnt - c0, 20);
`endif

        // 5: clk_enable low for 5 cycles at phase 30
        send(13'h0555, t0);
        repeat (30) tick();
        check("s5_phase30", phase, 30);
        clk_enable = 1'b0;
        #1;
        check("s5_acc_gated", acc_en, 0);
        frozen = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (phase == 30 && !acc_en && !shift_en) frozen++;
        end
        check("s5_frozen", frozen, 5);
        clk_enable = 1'b1;
        t_last = -1;
        for (int k = 0; k < 100 && t_last < 0; k++) begin
            tick();
            if (phase_last) t_last = cyc - t0;
        end
        check("s5_last_at", t_last, 65);
        repeat (3) tick();
        check("s5_back_idle", busy, 0);

        // 6: reset mid-MAC
        send(13'h1FFF, t0);
        repeat (40) tick();
        check("s6_phase40", phase, 40);
        reset = 1'b0;
        #1;
        check("s6_ready_rst", in_ready, 0);
        tick();
        reset = 1'b1;
        check("s6_idle", busy, 0);
        check("s6_phase0", phase, 0);
        n_ov = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            n_ov += out_valid;
        end
        check("s6_no_ov", n_ov, 0);
        check("s6_ready", in_ready, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
